spi_shift_engine: RTL and testbench

//  SPI master shift engine: serialises one DATA_WIDTH word per transfer, samples MISO, returns the received word.

---
 rtl/spi_pkg.sv | 16 +
 rtl/spi_shift_engine.sv | 161 ++++++++++++++++
 tb/tb_spi_shift_engine.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI shift engine: FSM states and the latched SPI mode.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI master shift engine: one DATA_WIDTH word per transfer, SCLK half-periods
// paced by prescaler ticks, full-duplex MOSI/MISO with selectable bit order.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter bit LSB_FIRST  = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  tick_hi_i,
    input  logic                  tick_lo_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic [DATA_WIDTH-1:0] tx_data_i,
    output logic                  rx_valid_o,
    output logic [DATA_WIDTH-1:0] rx_data_o,
    output logic                  busy_o,
    output logic                  sclk_o,
    output logic                  mosi_o,
    input  logic                  miso_i,
    output logic                  cs_n_o
);

    localparam int            CW        = $clog2(2*DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_EDGE = CW'(2*DATA_WIDTH - 1);

    spi_state_t            r_state, w_state_nx;
    spi_mode_t             r_mode;
    logic [CW-1:0]         r_edge_cnt;
    logic [DATA_WIDTH-1:0] r_tx, r_rx, r_rx_data;
    logic                  r_sclk, r_mosi, r_cs_n, r_rx_valid;

    logic                  w_tick, w_accept, w_edge, w_done, w_last;
    logic                  w_leading, w_sample, w_drive;
    logic [DATA_WIDTH-1:0] w_tx_shifted, w_rx_shifted;
    logic                  w_tx_first, w_tx_next, w_data_first;

    // Both prescaler pulses collapse into one tick, so an illegal overlap still advances once.
    assign w_tick    = tick_hi_i | tick_lo_i;
    assign w_last    = (r_edge_cnt == LAST_EDGE);
    assign w_leading = ~r_edge_cnt[0];
    // CPHA=0 samples on leading edges and drives on trailing; CPHA=1 is the mirror.
    assign w_sample  = w_edge & (w_leading ^ r_mode.cpha);
    assign w_drive   = w_edge & ~(w_leading ^ r_mode.cpha);

    // Bit-order dependent views of the shift registers.
    assign w_tx_shifted = LSB_FIRST ? {1'b0, r_tx[DATA_WIDTH-1:1]} : {r_tx[DATA_WIDTH-2:0], 1'b0};
    assign w_rx_shifted = LSB_FIRST ? {miso_i, r_rx[DATA_WIDTH-1:1]} : {r_rx[DATA_WIDTH-2:0], miso_i};
    assign w_tx_first   = LSB_FIRST ? r_tx[0] : r_tx[DATA_WIDTH-1];
    assign w_tx_next    = LSB_FIRST ? r_tx[1] : r_tx[DATA_WIDTH-2];
    assign w_data_first = LSB_FIRST ? tx_data_i[0] : tx_data_i[DATA_WIDTH-1];

    assign tx_ready_o = (r_state == IDLE);
    assign busy_o     = (r_state != IDLE);
    assign sclk_o     = r_sclk;
    assign mosi_o     = r_mosi;
    assign cs_n_o     = r_cs_n;
    assign rx_valid_o = r_rx_valid;
    assign rx_data_o  = r_rx_data;

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_state_nx;
    end

    // Next-state logic and per-cycle strobes; ticks in IDLE are never consumed.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_edge     = 1'b0;
        w_done     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (tx_valid_i) begin
                    w_accept   = 1'b1;
                    w_state_nx = SETUP;
                end
            end
            SETUP: begin
                if (w_tick) w_state_nx = SHIFT;
            end
            SHIFT: begin
                if (w_tick) begin
                    w_edge = 1'b1;
                    if (w_last) w_state_nx = HOLD;
                end
            end
            HOLD: begin
                if (w_tick) begin
                    w_done     = 1'b1;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    // Serial datapath: SCLK generation, edge counting, tx/rx shifting, word hand-off.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mode     <= '0;
            r_edge_cnt <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_rx_data  <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_sclk <= cpol_i;
                    if (w_accept) begin
                        r_tx       <= tx_data_i;
                        r_rx       <= '0;
                        r_mode     <= '{cpol: cpol_i, cpha: cpha_i};
                        r_cs_n     <= 1'b0;
                        r_edge_cnt <= '0;
                        // CPHA=0 needs the first bit on the wire before the first leading edge.
                        if (!cpha_i) r_mosi <= w_data_first;
                    end
                end
                SETUP: begin
                    if (w_tick) r_edge_cnt <= '0;
                end
                SHIFT: begin
                    if (w_edge) begin
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                        if (w_sample) r_rx <= w_rx_shifted;
                        if (w_drive) begin
                            if (r_mode.cpha) begin
                                r_mosi <= w_tx_first;
                                r_tx   <= w_tx_shifted;
                            end else if (!w_last) begin
                                r_mosi <= w_tx_next;
                                r_tx   <= w_tx_shifted;
                            end
                        end
                    end
                end
                HOLD: begin
                    if (w_done) begin
                        r_cs_n     <= 1'b1;
                        r_rx_data  <= r_rx;
                        r_rx_valid <= 1'b1;
                        r_edge_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Bench for spi_shift_engine: an MSB-first and an LSB-first instance run in lockstep
// against a behavioural SPI slave that drives MISO and captures MOSI per SPI mode rules.
module tb_spi_shift_engine;
    import spi_pkg::*;

    localparam int W = 8;
    localparam int M_SLAVE = 0, M_LOOP = 1, M_ONE = 2;

    logic clk, rst_n;
    logic tick_hi, tick_lo, cpol, cpha, tx_valid;
    logic [W-1:0] tx_data;
    logic tx_ready [2], rx_valid [2], busy [2], sclk [2], mosi [2], miso [2], cs_n [2];
    logic [W-1:0] rx_data [2];
    logic m_slave [2];

    int presc = 2, pcnt = 0, miso_mode = M_SLAVE;
    bit both_en = 0, ph = 0;
    logic [W-1:0] g_rxw = '0;

    int n_chk = 0, n_err = 0, n_exp = 0;

    // Monitor / slave state per instance.
    int edges [2], samp [2], drv [2], lat [2], viol [2], hi_cnt [2], n_acc [2], n_rx [2];
    logic [W-1:0] cap [2], a_tx [2], a_exp [2], a_rxw [2];
    logic a_cpol [2], a_cpha [2], act [2], prev_ready [2], prev_sclk [2], prev_mosi [2];

    spi_shift_engine #(.DATA_WIDTH(W), .LSB_FIRST(1'b0)) u_msb (
        .clk_i(clk), .rst_ni(rst_n), .tick_hi_i(tick_hi), .tick_lo_i(tick_lo),
        .cpol_i(cpol), .cpha_i(cpha), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready[0]),
        .tx_data_i(tx_data), .rx_valid_o(rx_valid[0]), .rx_data_o(rx_data[0]),
        .busy_o(busy[0]), .sclk_o(sclk[0]), .mosi_o(mosi[0]), .miso_i(miso[0]), .cs_n_o(cs_n[0]));

    spi_shift_engine #(.DATA_WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (
        .clk_i(clk), .rst_ni(rst_n), .tick_hi_i(tick_hi), .tick_lo_i(tick_lo),
        .cpol_i(cpol), .cpha_i(cpha), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready[1]),
        .tx_data_i(tx_data), .rx_valid_o(rx_valid[1]), .rx_data_o(rx_data[1]),
        .busy_o(busy[1]), .sclk_o(sclk[1]), .mosi_o(mosi[1]), .miso_i(miso[1]), .cs_n_o(cs_n[1]));

    assign miso[0] = (miso_mode == M_LOOP) ? mosi[0] : (miso_mode == M_ONE) ? 1'b1 : m_slave[0];
    assign miso[1] = (miso_mode == M_LOOP) ? mosi[1] : (miso_mode == M_ONE) ? 1'b1 : m_slave[1];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Bit position of the k-th bit on the wire for instance i (0: MSB first, 1: LSB first).
    function automatic int pos(input int k, input int i);
        return (i == 1) ? k : W - 1 - k;
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Prescaler model: one tick every presc cycles, alternating high/low pulses.
    initial begin
        tick_hi = 0; tick_lo = 0;
        forever begin
            @(negedge clk);
            tick_hi = 0; tick_lo = 0;
            pcnt++;
            if (pcnt >= presc) begin
                pcnt = 0;
                ph = !ph;
                if (both_en && $urandom_range(0, 3) == 0) begin
                    tick_hi = 1; tick_lo = 1;
                end else if (ph) tick_hi = 1;
                else             tick_lo = 1;
            end
        end
    end

    // Slave model and transfer monitor, sampled 1 time unit after each rising edge.
    initial begin
        bit lead, drive_now;
        for (int i = 0; i < 2; i++) begin
            act[i] = 0; n_acc[i] = 0; n_rx[i] = 0; hi_cnt[i] = 0; m_slave[i] = 0;
            prev_ready[i] = 1; prev_sclk[i] = 0; prev_mosi[i] = 0;
            edges[i] = 0; samp[i] = 0; drv[i] = 0; lat[i] = 0; viol[i] = 0; cap[i] = '0;
        end
        forever begin
            @(posedge clk); #1;
            for (int i = 0; i < 2; i++) begin
                drive_now = 0;
                if (!rst_n) begin
                    act[i] = 0;
                end else if (prev_ready[i] && !tx_ready[i]) begin
                    chk($sformatf("cs_gap%0d", i), 32'(hi_cnt[i] >= 1), 32'd1);
                    act[i] = 1; lat[i] = 0; edges[i] = 0; samp[i] = 0; drv[i] = 0;
                    viol[i] = 0; cap[i] = '0;
                    a_tx[i] = tx_data; a_cpol[i] = cpol; a_cpha[i] = cpha; a_rxw[i] = g_rxw;
                    a_exp[i] = (miso_mode == M_ONE) ? '1 : (miso_mode == M_LOOP) ? tx_data : g_rxw;
                    n_acc[i]++;
                    if (!cpha) begin
                        m_slave[i] = g_rxw[pos(0, i)];
                        drv[i] = 1;
                    end
                end else if (act[i]) begin
                    if (tick_hi || tick_lo) lat[i]++;
                    if (sclk[i] != prev_sclk[i]) begin
                        lead = (edges[i] % 2) == 0;
                        edges[i]++;
                        if (lead ^ a_cpha[i]) begin
                            if (samp[i] < W) cap[i][pos(samp[i], i)] = mosi[i];
                            samp[i]++;
                        end else begin
                            drive_now = 1;
                            if (drv[i] < W) m_slave[i] = a_rxw[i][pos(drv[i], i)];
                            drv[i]++;
                        end
                    end
                    if (!cs_n[i] && mosi[i] != prev_mosi[i] && !drive_now) viol[i]++;
                    if (rx_valid[i]) begin
                        chk($sformatf("rx_data%0d", i), 32'(rx_data[i]), 32'(a_exp[i]));
                        chk($sformatf("mosi_word%0d", i), 32'(cap[i]), 32'(a_tx[i]));
                        chk($sformatf("sclk_edges%0d", i), edges[i], 2 * W);
                        chk($sformatf("sclk_idle%0d", i), 32'(sclk[i]), 32'(a_cpol[i]));
                        chk($sformatf("latency%0d", i), lat[i], 2 * W + 2);
                        chk($sformatf("mosi_stable%0d", i), viol[i], 0);
                        chk($sformatf("cs_end%0d", i), 32'(cs_n[i]), 32'd1);
                        act[i] = 0;
                        n_rx[i]++;
                    end
                end else if (rx_valid[i]) begin
                    chk($sformatf("spurious_rx%0d", i), 32'(rx_valid[i]), 32'd0);
                end
                hi_cnt[i]     = cs_n[i] ? hi_cnt[i] + 1 : 0;
                prev_ready[i] = tx_ready[i];
                prev_sclk[i]  = sclk[i];
                prev_mosi[i]  = mosi[i];
            end
        end
    end

    task automatic start_xfer(input logic [W-1:0] d, input logic pl, input logic pa,
                              input int mm, input logic [W-1:0] rw);
        int target, t;
        @(negedge clk);
        tx_data = d; cpol = pl; cpha = pa; miso_mode = mm; g_rxw = rw; tx_valid = 1;
        target = n_acc[0] + 1;
        t = 0;
        while (n_acc[0] < target && t < 200) begin
            @(negedge clk);
            t++;
        end
        tx_valid = 0;
        if (n_acc[0] < target) chk("acc_timeout", n_acc[0], target);
    endtask

    task automatic wait_rx(input int target);
        int t = 0;
        while (n_rx[0] < target && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (n_rx[0] < target) chk("rx_timeout", n_rx[0], target);
    endtask

    task automatic send(input logic [W-1:0] d, input logic pl, input logic pa,
                        input int mm, input logic [W-1:0] rw);
        int r0 = n_rx[0];
        start_xfer(d, pl, pa, mm, rw);
        wait_rx(r0 + 1);
        n_exp++;
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_cs%0d", tag, i), 32'(cs_n[i]), 32'd1);
            chk($sformatf("%s_sclk%0d", tag, i), 32'(sclk[i]), 32'd0);
            chk($sformatf("%s_mosi%0d", tag, i), 32'(mosi[i]), 32'd0);
            chk($sformatf("%s_rxv%0d", tag, i), 32'(rx_valid[i]), 32'd0);
            chk($sformatf("%s_rxd%0d", tag, i), 32'(rx_data[i]), 32'd0);
            chk($sformatf("%s_rdy%0d", tag, i), 32'(tx_ready[i]), 32'd1);
            chk($sformatf("%s_busy%0d", tag, i), 32'(busy[i]), 32'd0);
        end
    endtask

    initial begin
        int a0, r0, t;
        rst_n = 0; tx_valid = 0; tx_data = '0; cpol = 0; cpha = 0;
        repeat (3) @(negedge clk);
        #1 chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // Mode 0 loopback.
        presc = 2;
        send(8'hA5, 1'b0, 1'b0, M_LOOP, 8'h00);
        // Mode 3, MISO tied high; SCLK must idle high afterwards.
        send(8'h3C, 1'b1, 1'b1, M_ONE, 8'h00);
        repeat (3) @(negedge clk);
        chk("idle_cpol1", 32'(sclk[0]), 32'd1);
        // Mode 1 loopback (LSB-first instance sends 1 first).
        send(8'h01, 1'b0, 1'b1, M_LOOP, 8'h00);

        // Back-to-back words with tx_valid held high.
        r0 = n_rx[0]; a0 = n_acc[0];
        @(negedge clk);
        tx_data = 8'h12; cpol = 0; cpha = 0; miso_mode = M_SLAVE; g_rxw = 8'h9D; tx_valid = 1;
        t = 0;
        while (n_acc[0] < a0 + 1 && t < 200) begin @(negedge clk); t++; end
        tx_data = 8'h34;
        t = 0;
        while (n_acc[0] < a0 + 2 && t < 300) begin @(negedge clk); t++; end
        tx_valid = 0;
        chk("b2b_accepts", n_acc[0], a0 + 2);
        wait_rx(r0 + 2);
        n_exp += 2;

        // tx_valid while busy must be dropped.
        a0 = n_acc[0]; r0 = n_rx[0];
        start_xfer(8'h5A, 1'b1, 1'b0, M_SLAVE, 8'hE7);
        repeat (6) @(negedge clk);
        tx_data = 8'hFF; tx_valid = 1;
        @(negedge clk);
        tx_valid = 0;
        wait_rx(r0 + 1);
        n_exp++;
        repeat (5) @(negedge clk);
        chk("busy_ignored", n_acc[0], a0 + 1);

        // Asynchronous reset part-way through SHIFT.
        r0 = n_rx[0];
        start_xfer(8'hC3, 1'b0, 1'b0, M_SLAVE, 8'h6B);
        t = 0;
        while (edges[0] < 5 && t < 200) begin @(negedge clk); t++; end
        chk("rst_at_edges", edges[0], 5);
        rst_n = 0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_cs%0d", i), 32'(cs_n[i]), 32'd1);
            chk($sformatf("rst_sclk%0d", i), 32'(sclk[i]), 32'd0);
            chk($sformatf("rst_busy%0d", i), 32'(busy[i]), 32'd0);
        end
        repeat (4) @(negedge clk);
        rst_n = 1;
        repeat (4) @(negedge clk);
        chk("rst_no_rx", n_rx[0], r0);
        send(8'h96, 1'b0, 1'b0, M_SLAVE, 8'h4E);

        // Randomised transfers: mode, prescaler, MISO source and overlapping ticks.
        for (int k = 0; k < 24; k++) begin
            presc   = $urandom_range(1, 4);
            both_en = $urandom_range(0, 1);
            send(8'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : M_SLAVE, 8'($urandom));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 5)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        chk("rx_total0", n_rx[0], n_exp);
        chk("rx_total1", n_rx[1], n_exp);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
